// File: rtl/multi_wave_gen_pkg.sv
// rtl/multi_wave_gen_pkg.sv - shared waveform mode encodings and midscale helper
package multi_wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_DC     = 2'b11
    } wave_mode_t;

    function automatic int unsigned mid_value(input int unsigned out_w);
        return 32'd1 << (out_w - 1);
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - combinational phase-to-sample shaping for all four modes
module wave_shaper
    import multi_wave_gen_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 12
) (
    input  logic [PHASE_W-1:0] phase,
    input  logic [PHASE_W-1:0] duty,
    input  wave_mode_t         mode,
    input  logic [OUT_W-2:0]   amp,
    output logic [OUT_W-1:0]   sample
);

    localparam logic [OUT_W-1:0] MID = OUT_W'(mid_value(OUT_W));

    logic [OUT_W-1:0] lo;
    logic [OUT_W-1:0] hi;
    logic [OUT_W-1:0] amp2;
    logic [OUT_W-1:0] saw_idx;
    logic [OUT_W-1:0] tri_raw;
    logic [OUT_W-1:0] tri_idx;
    logic [OUT_W-1:0] ramp_idx;
    logic [OUT_W-1:0] ramp;

    assign lo      = MID - {1'b0, amp};
    assign hi      = MID + {1'b0, amp};
    assign amp2    = {amp, 1'b0};
    assign saw_idx = phase[PHASE_W-1 -: OUT_W];
    assign tri_raw = phase[PHASE_W-2 -: OUT_W];
    assign tri_idx = phase[PHASE_W-1] ? ~tri_raw : tri_raw;

    // Full-width product keeps the ramp strictly below 2*amp, so lo+ramp never passes hi.
    assign ramp_idx = (mode == MODE_TRI) ? tri_idx : saw_idx;
    assign ramp     = OUT_W'(((2*OUT_W)'(ramp_idx) * (2*OUT_W)'(amp2)) >> OUT_W);

    always_comb begin
        sample = MID;
        case (mode)
            MODE_SQUARE: sample = (phase < duty) ? hi : lo;
            MODE_SAW:    sample = lo + ramp;
            MODE_TRI:    sample = lo + ramp;
            default:     sample = MID;
        endcase
    end

endmodule

// File: rtl/multi_wave_gen.sv
// rtl/multi_wave_gen.sv - phase-accumulator waveform generator with wrap-aligned config handoff
module multi_wave_gen
    import multi_wave_gen_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [PHASE_W-1:0] cfg_duty,
    input  logic [1:0]         cfg_mode,
    input  logic [OUT_W-2:0]   cfg_amp,
    output logic [OUT_W-1:0]   wave,
    output logic               sync
);

    typedef struct packed {
        logic [PHASE_W-1:0] inc;
        logic [PHASE_W-1:0] duty;
        wave_mode_t         mode;
        logic [OUT_W-2:0]   amp;
    } wave_cfg_t;

    wave_cfg_t          act_cfg;
    wave_cfg_t          pend_cfg;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   phase_sum;
    logic               carry;
    logic               period_start;
    logic [OUT_W-1:0]   shaped;

    assign phase_sum = {1'b0, phase} + {1'b0, act_cfg.inc};
    assign carry     = phase_sum[PHASE_W];

    wave_shaper #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_shaper (
        .phase  (phase),
        .duty   (act_cfg.duty),
        .mode   (act_cfg.mode),
        .amp    (act_cfg.amp),
        .sample (shaped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase         <= '0;
            wave          <= '0;
            sync          <= 1'b0;
            period_start  <= 1'b0;
            cfg_ready     <= 1'b1;
            pend_cfg      <= '0;
            act_cfg.inc   <= '0;
            act_cfg.duty  <= {1'b1, {(PHASE_W-1){1'b0}}};
            act_cfg.mode  <= MODE_DC;
            act_cfg.amp   <= '0;
        end else begin
            // period_start remembers a wrap so sync lands on the first sample of the new period
            if (enable) begin
                phase        <= phase_sum[PHASE_W-1:0];
                wave         <= shaped;
                sync         <= period_start;
                period_start <= carry;
            end else begin
                sync <= 1'b0;
            end

            if (!cfg_ready) begin
                if (!enable || carry) begin
                    act_cfg   <= pend_cfg;
                    cfg_ready <= 1'b1;
                end
            end else if (cfg_valid) begin
                pend_cfg.inc  <= cfg_inc;
                pend_cfg.duty <= cfg_duty;
                pend_cfg.mode <= wave_mode_t'(cfg_mode);
                pend_cfg.amp  <= cfg_amp;
                cfg_ready     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/multi_wave_gen.md
MULTI_WAVE_GEN -- requirements
Module: multi_wave_gen

Interface
REQ-001 Parameter: PHASE_W, default 24, phase accumulator width; SHALL satisfy PHASE_W >= OUT_W+1.
REQ-002 Parameter: OUT_W, default 12, output sample width, offset-binary, midscale MID = 2^(OUT_W-1).
REQ-003 Port: clk  input  1  clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: enable  input  1  advance phase when high; hold phase when low.
REQ-006 Port: cfg_valid  input  1  new configuration offered.
REQ-007 Port: cfg_ready  output  1  configuration slot free.
REQ-008 Port: cfg_inc  input  PHASE_W  phase increment per cycle (tuning word).
REQ-009 Port: cfg_duty  input  PHASE_W  square high/low threshold.
REQ-010 Port: cfg_mode  input  2  00 SQUARE, 01 SAW, 10 TRIANGLE, 11 DC.
REQ-011 Port: cfg_amp  input  OUT_W-1  peak deviation from MID.
REQ-012 Port: wave  output  OUT_W  registered sample.
REQ-013 Port: sync  output  1  one-cycle pulse marking period start, aligned with wave.

Function
REQ-014 Config transfer SHALL occur on a cycle with cfg_valid && cfg_ready; fields captured into a pending register, cfg_ready deasserts next cycle.
REQ-015 Pending config SHALL become active on the cycle the accumulator wraps (carry out), or on the next cycle if enable is low; cfg_ready reasserts the cycle after activation.
REQ-016 cfg_valid while cfg_ready low SHALL be ignored; no queueing beyond one pending entry.
REQ-017 Accumulator: phase <= (phase + inc) mod 2^PHASE_W when enable; wrap = carry out of that add.
REQ-018 Latency: wave and sync SHALL reflect the phase value of the previous cycle (1-cycle registered output).
REQ-019 SQUARE: phase < duty -> MID+amp, else MID-amp; duty=0 gives constant MID-amp.
REQ-020 Let s = phase[PHASE_W-1 -: OUT_W]; SAW = MID-amp + ((s*2*amp) >> OUT_W), full-precision product, no overflow.
REQ-021 TRIANGLE: t = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W]; value = MID-amp + ((t*2*amp) >> OUT_W).
REQ-022 DC: wave = MID regardless of phase.
REQ-023 All outputs SHALL stay within [MID-amp, MID+amp]; amp max 2^(OUT_W-1)-1 never wraps.
REQ-024 sync SHALL be high exactly one cycle after each wrap; never when enable low or inc=0.
REQ-025 Mode/amp/duty change takes effect on the first sample after activation; no glitch mid-period.

Reset
REQ-026 On rst: phase=0, wave=0, sync=0, pending cleared, cfg_ready=1, active config inc=0, duty=2^(PHASE_W-1), mode=DC, amp=0.
REQ-027 rst asserted mid-operation SHALL discard any pending config; first post-reset wave = MID.

Structure
REQ-028 Mode encodings and MID computation SHALL live in a shared waveform package.
REQ-029 Sample shaping (REQ-019..022) SHALL be one sub-module, wave_shaper, combinational with output register in the parent.

Verification
REQ-030 Square: inc=0x100000, duty=0x800000, amp=4, enable=1 -> repeating 8 x 0x804 then 8 x 0x7FC, sync every 16 cycles.
REQ-031 Saw: inc=0x100000, amp=0x7FF -> wave 0x001 at sync, rising by 0xFF/0x100 steps, last sample 0xEFF.
REQ-032 Handshake: second cfg_valid right after acceptance -> cfg_ready low, ignored until wrap; new mode seen on first sample after sync.
REQ-033 enable low with pending config -> applied next cycle, phase and wave frozen, no sync.
REQ-034 rst mid-period with pending config -> wave=0 then 0x800 (DC), cfg_ready=1, old pending never applied.
